// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, ALU codes, opcodes and select encodings
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Only beq is implemented among branches; shifts and xor are outside the subset.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: ok = 1'b1;
      OP_RTYPE, OP_ITYPE:
        ok = !(funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101);
      OP_BRANCH: ok = (funct3 == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       MemReq;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] ALUControl;
  logic       MemTimeout;
  logic [3:0] StateOut;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegWrite, ALUControl, MemTimeout, StateOut
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegWrite, ALUControl, MemTimeout, StateOut
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - ALUOp/funct to ALUControl decode
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // op[5] separates R-type from I-type so addi never becomes a subtract.
          3'b000:         alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010, 3'b011: alu_control = ALU_SLT;
          3'b110:         alu_control = ALU_OR;
          3'b111:         alu_control = ALU_AND;
          default:        alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I-subset control FSM; ILLEGAL_TRAP_EN selects trap-on-illegal
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       alu_op;
  logic [3:0]       alu_ctrl;
  logic             pcw, irw, rw, mw, mreq;
  logic             adr;
  logic [1:0]       srca, srcb, res, imm;

  multicycle_control_alu_decoder u_alu_dec (
    .alu_op     (alu_op),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .alu_control(alu_ctrl)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (bus.MemReady) state_next = S_DECODE;
      S_DECODE: begin
        if (!is_legal(bus.op, bus.funct3)) state_next = ILLEGAL_NEXT;
        else begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_RTYPE:          state_next = S_EXECR;
            OP_ITYPE:          state_next = S_EXECI;
            OP_BRANCH:         state_next = S_BEQ;
            OP_JAL:            state_next = S_JAL;
            default:           state_next = ILLEGAL_NEXT;
          endcase
        end
      end
      S_MEMADR:   state_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MemReady) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_next = S_FETCH;
      S_EXECR,
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`else
      S_TRAP:     state_next = S_FETCH;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // Any state change clears the count, which covers entry into every waiting state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) wait_cnt <= '0;
      else if (mreq && !bus.MemReady && wait_cnt != CNT_W'(MEM_TIMEOUT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    pcw    = 1'b0;
    irw    = 1'b0;
    rw     = 1'b0;
    mw     = 1'b0;
    mreq   = 1'b0;
    adr    = ADR_PC;
    srca   = SRCA_PC;
    srcb   = SRCB_RD2;
    res    = RES_ALUOUT;
    imm    = IMM_I;
    alu_op = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mreq = 1'b1;
        irw  = bus.MemReady;
        pcw  = bus.MemReady;
        srcb = SRCB_FOUR;
        res  = RES_ALURESULT;
      end
      S_DECODE: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        imm  = IMM_B;
      end
      S_MEMADR: begin
        srca = SRCA_RD1;
        srcb = SRCB_IMM;
        imm  = (bus.op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mreq = 1'b1;
        adr  = ADR_ALUOUT;
      end
      S_MEMWB: begin
        res = RES_DATA;
        rw  = 1'b1;
      end
      S_MEMWRITE: begin
        mreq = 1'b1;
        mw   = 1'b1;
        adr  = ADR_ALUOUT;
      end
      S_EXECR: begin
        srca   = SRCA_RD1;
        srcb   = SRCB_RD2;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        srca   = SRCA_RD1;
        srcb   = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: rw = 1'b1;
      S_BEQ: begin
        srca   = SRCA_RD1;
        srcb   = SRCB_RD2;
        alu_op = ALUOP_SUB;
        pcw    = bus.Zero;
      end
      // ALUOut still holds the DECODE target, so PC loads it while ALU computes OldPC+4.
      S_JAL: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_FOUR;
        pcw  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite    = pcw & rst_n;
  assign bus.IRWrite    = irw & rst_n;
  assign bus.RegWrite   = rw & rst_n;
  assign bus.MemWrite   = mw & rst_n;
  assign bus.MemReq     = mreq & rst_n;
  assign bus.MemTimeout = mreq & rst_n & (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign bus.AdrSrc     = adr;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ResultSrc  = res;
  assign bus.ImmSrc     = imm;
  assign bus.ALUControl = alu_ctrl;
  assign bus.StateOut   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - vector table, corner sequences and random trace check
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, mreq, mto;
    logic       adr;
    logic [1:0] srca, srcb, res, imm;
    logic [3:0] aluc;
  } obs_t;

  typedef struct {
    int st;
    bit ready;
    int k;
  } step_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    bit         f7b5;
    bit         zero;
    int         wf;
    int         wm;
    int         aluc;
    int         rw;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  bit cur_f7b5, cur_zero;
  int seen_rw;
  int seen_aluc;
  step_t trace[$];
  vec_t vecs[$];

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.StateOut;     o.pcw = bus.PCWrite;   o.irw = bus.IRWrite;
    o.rw = bus.RegWrite;     o.mw = bus.MemWrite;   o.mreq = bus.MemReq;
    o.mto = bus.MemTimeout;  o.adr = bus.AdrSrc;    o.srca = bus.ALUSrcA;
    o.srcb = bus.ALUSrcB;    o.res = bus.ResultSrc; o.imm = bus.ImmSrc;
    o.aluc = bus.ALUControl;
    return o;
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1101111) return 1'b1;
    if (op == 7'b0110011 || op == 7'b0010011) return !(f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
    if (op == 7'b1100011) return f3 == 3'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input bit f7b5, input bit rtype);
    if (f3 == 3'd0) return (rtype && f7b5) ? 4'b0110 : 4'b0010;
    if (f3 == 3'd2 || f3 == 3'd3) return 4'b0111;
    if (f3 == 3'd6) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic bit is_mem_state(input int st);
    return st == 0 || st == 3 || st == 5;
  endfunction

  // Expected outputs for one cycle, with a mask of the fields the state defines.
  function automatic void exp_of(input int st, input bit ready, input int k,
                                 output obs_t e, output obs_t m);
    e = '0; m = '0;
    e.st = st[3:0];
    m.st = '1; m.pcw = 1; m.irw = 1; m.rw = 1; m.mw = 1; m.mreq = 1; m.mto = 1;
    if (is_mem_state(st)) begin
      e.mreq = 1'b1;
      e.mto  = (k >= MEM_TIMEOUT);
    end
    case (st)
      0: begin
        e.irw = ready; e.pcw = ready;
        e.adr = 0; e.srca = 2'b00; e.srcb = 2'b10; e.aluc = 4'b0010; e.res = 2'b10;
        m.adr = 1; m.srca = '1; m.srcb = '1; m.aluc = '1; m.res = '1;
      end
      1: begin
        e.srca = 2'b01; e.srcb = 2'b01; e.imm = 2'b10; e.aluc = 4'b0010;
        m.srca = '1; m.srcb = '1; m.imm = '1; m.aluc = '1;
      end
      2: begin
        e.srca = 2'b10; e.srcb = 2'b01; e.aluc = 4'b0010;
        e.imm = (cur_op == 7'b0100011) ? 2'b01 : 2'b00;
        m.srca = '1; m.srcb = '1; m.aluc = '1; m.imm = '1;
      end
      3: begin e.adr = 1; m.adr = 1; end
      4: begin e.res = 2'b01; e.rw = 1; m.res = '1; end
      5: begin e.adr = 1; e.mw = 1; m.adr = 1; end
      6: begin
        e.srca = 2'b10; e.srcb = 2'b00; e.aluc = funct_alu(cur_f3, cur_f7b5, 1'b1);
        m.srca = '1; m.srcb = '1; m.aluc = '1;
      end
      7: begin
        e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b00; e.aluc = funct_alu(cur_f3, cur_f7b5, 1'b0);
        m.srca = '1; m.srcb = '1; m.imm = '1; m.aluc = '1;
      end
      8: begin e.res = 2'b00; e.rw = 1; m.res = '1; end
      9: begin
        e.srca = 2'b10; e.srcb = 2'b00; e.aluc = 4'b0110; e.res = 2'b00; e.pcw = cur_zero;
        m.srca = '1; m.srcb = '1; m.aluc = '1; m.res = '1;
      end
      10: begin
        e.srca = 2'b01; e.srcb = 2'b10; e.aluc = 4'b0010; e.res = 2'b00; e.pcw = 1;
        m.srca = '1; m.srcb = '1; m.aluc = '1; m.res = '1;
      end
      default: ;
    endcase
  endfunction

  task automatic check_obs(input string name, input obs_t e, input obs_t m);
    obs_t a;
    a = sample();
    checks++;
    if (((a ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s: got %h want %h (mask %h)", name, a, e, m);
    end
  endtask

  task automatic check_reset(input string name);
    obs_t e, m;
    e = '0; m = '1;
    e.srcb = 2'b10; e.res = 2'b10; e.aluc = 4'b0010;
    check_obs(name, e, m);
  endtask

  // One clock: entered at posedge+1, checked at the falling edge.
  task automatic step(input int st, input bit ready, input int k, input string name);
    obs_t e, m, a;
    bus.MemReady = is_mem_state(st) ? ready : 1'($urandom_range(0, 1));
    bus.Zero = cur_zero;
    #4;
    exp_of(st, ready, k, e, m);
    check_obs($sformatf("%s st%0d k%0d", name, st, k), e, m);
    a = sample();
    if (a.rw) seen_rw++;
    if (st == 6 || st == 7 || st == 9) seen_aluc = int'(a.aluc);
    @(posedge clk);
    #1;
  endtask

  function automatic void push_wait(input int st, input int w);
    for (int i = 0; i <= w; i++) trace.push_back('{st, (i == w), i});
  endfunction

  // Instruction-level model: the phase sequence an instruction walks through.
  function automatic void build_trace(input int wf, input int wm);
    trace.delete();
    push_wait(0, wf);
    trace.push_back('{1, 1'b0, 0});
    if (!legal(cur_op, cur_f3)) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) trace.push_back('{11, 1'b0, 0});
`endif
    end else if (cur_op == 7'b0000011) begin
      trace.push_back('{2, 1'b0, 0}); push_wait(3, wm); trace.push_back('{4, 1'b0, 0});
    end else if (cur_op == 7'b0100011) begin
      trace.push_back('{2, 1'b0, 0}); push_wait(5, wm);
    end else if (cur_op == 7'b0110011) begin
      trace.push_back('{6, 1'b0, 0}); trace.push_back('{8, 1'b0, 0});
    end else if (cur_op == 7'b0010011) begin
      trace.push_back('{7, 1'b0, 0}); trace.push_back('{8, 1'b0, 0});
    end else if (cur_op == 7'b1100011) begin
      trace.push_back('{9, 1'b0, 0});
    end else begin
      trace.push_back('{10, 1'b0, 0}); trace.push_back('{8, 1'b0, 0});
    end
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input bit f7b5, input bit zero);
    cur_op = op; cur_f3 = f3; cur_f7b5 = f7b5; cur_zero = zero;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7b5;
    seen_rw = 0; seen_aluc = -1;
  endtask

  task automatic do_reset(input string name);
    bus.MemReady = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset(name);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input string name, input int wf, input int wm);
    build_trace(wf, wm);
    foreach (trace[i]) step(trace[i].st, trace[i].ready, trace[i].k, name);
`ifdef ILLEGAL_TRAP_EN
    if (!legal(cur_op, cur_f3)) do_reset({name, " trap reset"});
`endif
  endtask

  initial begin
    logic [6:0] ops[8];
    rst_n = 1'b0;
    bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    #2;
    check_reset("reset async");
    @(posedge clk);
    #1;
    check_reset("reset held");
    rst_n = 1'b1;

    vecs.push_back('{"add",   7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0,  2,  1});
    vecs.push_back('{"sub",   7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0,  6,  1});
    vecs.push_back('{"addi7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0,  2,  1});
    vecs.push_back('{"ori",   7'b0010011, 3'd6, 1'b0, 1'b0, 2, 0,  1,  1});
    vecs.push_back('{"andi",  7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0,  0,  1});
    vecs.push_back('{"slti",  7'b0010011, 3'd2, 1'b0, 1'b0, 0, 0,  7,  1});
    vecs.push_back('{"sltu",  7'b0110011, 3'd3, 1'b0, 1'b0, 0, 0,  7,  1});
    vecs.push_back('{"lw",    7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, -1,  1});
    vecs.push_back('{"sw",    7'b0100011, 3'd2, 1'b0, 1'b0, 0, 20, -1, 0});
    vecs.push_back('{"beq1",  7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0,  6,  0});
    vecs.push_back('{"beq0",  7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0,  6,  0});
    vecs.push_back('{"bne",   7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0, -1,  0});
    vecs.push_back('{"jal",   7'b1101111, 3'd0, 1'b0, 1'b0, 1, 0, -1,  1});
    vecs.push_back('{"op7f",  7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, -1,  0});
    vecs.push_back('{"slli",  7'b0010011, 3'd1, 1'b0, 1'b0, 0, 0, -1,  0});

    foreach (vecs[i]) begin
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7b5, vecs[i].zero);
      run_instr(vecs[i].name, vecs[i].wf, vecs[i].wm);
      checks++;
      if (seen_rw != vecs[i].rw) begin
        errors++;
        $display("FAIL %s regwrite count: got %0d want %0d", vecs[i].name, seen_rw, vecs[i].rw);
      end
      if (vecs[i].aluc >= 0) begin
        checks++;
        if (seen_aluc != vecs[i].aluc) begin
          errors++;
          $display("FAIL %s alucontrol: got %0d want %0d", vecs[i].name, seen_aluc, vecs[i].aluc);
        end
      end
    end

    // Reset while MEMREAD waits: everything drops at once, access is abandoned.
    set_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    step(0, 1'b1, 0, "rst-lw");
    step(1, 1'b0, 0, "rst-lw");
    step(2, 1'b0, 0, "rst-lw");
    step(3, 1'b0, 0, "rst-lw");
    step(3, 1'b0, 1, "rst-lw");
    do_reset("reset mid-memread");
    step(0, 1'b0, 0, "post-rst");
    step(0, 1'b1, 1, "post-rst");
    step(1, 1'b0, 0, "post-rst");
    step(2, 1'b0, 0, "post-rst");
    step(3, 1'b1, 0, "post-rst");
    step(4, 1'b0, 0, "post-rst");

    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1110011; ops[7] = 7'b0110111;
    for (int n = 0; n < 150; n++) begin
      int wf, wm;
      set_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      run_instr($sformatf("rand%0d", n), wf, wm);
    end

    cur_zero = 1'b0;
    step(0, 1'b0, 0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I-subset core; the producer side of the ALU's 4-bit ALUControl interface.
- Decodes op/funct3/funct7b5 from the instruction register.
- Sequences fetch/decode/execute/memory/writeback.
- Drives datapath mux selects, write strobes and ALUControl.
- Waits on a variable-latency memory through a MemReady handshake.

Parameters:
- MEM_TIMEOUT, 16: wait cycles on MemReady before MemTimeout asserts. Valid range 1..255.
- CNT_W, 8: width of the wait counter. Must hold MEM_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction bits [6:0].
- funct3  in  3  instruction bits [14:12].
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write request.
- MemReq  out  1  memory access request (read or write).
- IRWrite  out  1  IR/OldPC load strobe.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  ALU B select: 00 RD2, 01 Imm, 10 constant 4.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1  register file write strobe.
- ALUControl  out  4  ALU operation code.
- MemTimeout  out  1  wait count has reached MEM_TIMEOUT.
- StateOut  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset:
  - state <= FETCH and wait counter <= 0.
  - While rst_n is low, PCWrite, IRWrite, RegWrite, MemWrite, MemReq and MemTimeout are forced to 0.
  - Selects take their FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=0010, ImmSrc=00.
  - Reset mid-access abandons the access; no strobe fires in that cycle.
- ALUControl encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SET-LESS. 1100 NOR is never generated.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stay in FETCH until MemReady=1, then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=ADD (branch target).
  - Transitions by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ, only when funct3=000; otherwise treated as illegal
    - 1101111 -> JAL
    - any other op -> illegal
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=ADD. ImmSrc=00 for lw, 01 for sw. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Hold until MemReady, then go to FETCH. MemWrite stays high through the whole wait.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from the funct decode. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUControl from the funct decode. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- Funct decode (EXECR/EXECI):
  - funct3 000: SUB if R-type and funct7b5=1, else ADD.
  - funct3 010 or 011: SET-LESS.
  - funct3 110: OR.
  - funct3 111: AND.
  - funct3 001, 100, 101: illegal, detected in DECODE.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00. PCWrite = Zero. Next state FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=00, PCWrite=1.
  - Next state ALUWB, which writes OldPC+4.
  - Datapath ordering requirement: ALUOut holds the DECODE target when PCWrite fires.
- Wait counter:
  - Cleared on entry to any state that drives MemReq.
  - Increments each cycle that MemReq=1 and MemReady=0; saturates at MEM_TIMEOUT.
  - MemTimeout=1 while count==MEM_TIMEOUT and MemReq=1.
  - The FSM never aborts on timeout.
- Illegal instruction: behaviour depends on the optional feature.
- MemReady is ignored in states that do not drive MemReq.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Illegal instructions go from DECODE to TRAP.
  - TRAP asserts no strobes and stays until reset; StateOut=11.
- Undefined:
  - Illegal instructions go from DECODE to FETCH with no architectural write (NOP).
  - TRAP is unreachable.

Decomposition:
- Shared package:
  - state enum
  - ALUControl code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR
  - opcode constants
  - select encodings for AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc
- The ALU must consume the same ALUControl constants.
- One natural sub-module: alu_decoder, combinational, taking funct3, funct7b5, op[5] and a 2-bit ALUOp from the FSM to ALUControl.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 always -> 4 cycles FETCH->DECODE->EXECR->ALUWB; ALUControl=0010 in EXECR; RegWrite=1 only in ALUWB.
- sub (f7b5 1) -> ALUControl=0110; addi with f7b5=1 -> 0010; ori -> 0001; andi -> 0000; slti -> 0111.
- lw with MemReady low for 3 cycles in MEMREAD -> state holds; MemTimeout=0 with MEM_TIMEOUT=16; RegWrite in MEMWB exactly once; total 8 cycles.
- sw with MemReady held low 20 cycles -> MemWrite stays 1; MemTimeout rises after 16 waiting cycles; on MemReady=1 go to FETCH with counter cleared.
- beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; funct3=001 -> illegal path.
- op=1111111: with ILLEGAL_TRAP_EN -> StateOut=11 and no strobes for 10 cycles. Without it -> FETCH next cycle. rst_n low mid-MEMREAD -> StateOut=0 and all strobes 0 immediately.
